// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte at a time from an 8-bit FIFO and sends it
// as an 8N1 UART frame at CLKS_PER_BIT clocks per bit.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned IDX_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_CAP   = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                fifo_rd_q, fifo_rd_d;
  logic                tx_done_q, tx_done_d;
  logic                bit_end_c;

  assign bit_end_c = (cnt_q == CNT_LAST);

  // State and datapath registers; reset forces the line idle at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      fifo_rd_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      fifo_rd_q <= fifo_rd_d;
      tx_done_q <= tx_done_d;
    end
  end

  // Next state, counters and shifter; outputs are decoded from the next state
  // so the registered versions line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;
    fifo_rd_d = 1'b0;
    tx_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_RD;
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        shift_d   = fifo_data;
        cnt_d     = '0;
        bit_idx_d = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (bit_end_c) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          cnt_d     = '0;
          shift_d   = {1'b0, shift_q[DATA_W-1:1]};
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_LAST) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    fifo_rd_d = (state_d == S_RD);
    busy_d    = (state_d != S_IDLE);
    tx_done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign fifo_rd = fifo_rd_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a registered-read
// FIFO model; frames are captured cycle by cycle and compared whole.
module tb_fifo_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       tx_done;

  logic [7:0] mem [16];
  logic [4:0] wr_ptr = 5'd0;
  logic [4:0] rd_ptr = 5'd0;
  logic       tog = 1'b0;
  logic       tog_en = 1'b0;
  int         rd_cnt = 0;
  int         done_cnt = 0;
  int         underflow = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // FIFO model: 1-cycle registered read, optional empty-flag toggling
  assign fifo_empty = (rd_ptr == wr_ptr) || (tog_en && tog);

  always @(posedge clk) begin
    tog <= ~tog;
    if (fifo_rd) begin
      if (rd_ptr == wr_ptr) begin
        underflow <= underflow + 1;
      end else begin
        fifo_data <= mem[rd_ptr[3:0]];
        rd_ptr    <= rd_ptr + 5'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (fifo_rd) rd_cnt <= rd_cnt + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  function automatic logic [FRAME-1:0] exp_frame(input logic [7:0] b);
    logic [FRAME-1:0] v;
    int p;
    v = '0;
    for (int i = 0; i < int'(FRAME); i++) begin
      p = i / int'(CPB);
      if (p == 0)      v[i] = 1'b0;
      else if (p == 9) v[i] = 1'b1;
      else             v[i] = b[p-1];
    end
    return v;
  endfunction

  // Counts negedges with tx high until tx is seen low; bounded.
  task automatic wait_fall(input string tag, output int gap, output logic ok);
    gap = 0;
    ok  = 1'b1;
    @(negedge clk);
    while (tx !== 1'b0 && gap < 200) begin
      gap++;
      @(negedge clk);
    end
    if (tx !== 1'b0) begin
      chk(tag, 64'(tx), 64'(0));
      ok = 1'b0;
    end
  endtask

  // Samples one frame starting at the negedge where tx is first low.
  task automatic capture_frame(input string tag, output logic [FRAME-1:0] txv,
                               output logic [FRAME-1:0] donev, output logic busy_all,
                               output int gap);
    logic ok;
    txv      = '0;
    donev    = '0;
    busy_all = 1'b1;
    wait_fall(tag, gap, ok);
    if (!ok) return;
    for (int i = 0; i < int'(FRAME); i++) begin
      txv[i]   = tx;
      donev[i] = tx_done;
      busy_all = busy_all & busy;
      if (i < int'(FRAME) - 1) @(negedge clk);
    end
  endtask

  logic [FRAME-1:0] txv, donev, txv2, donev2;
  logic [FRAME-1:0] done_last;
  logic             ball, ball2, ok;
  int               gap, gap2, rd0, d0;

  initial begin
    done_last = '0;
    done_last[FRAME-1] = 1'b1;
    rst = 1'b1;
    #1 rst = 1'b0;
    push(8'h2A);

    // Reset held with a non-empty FIFO
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      ok = ok & (tx === 1'b1) & (busy === 1'b0) & (fifo_rd === 1'b0) & (tx_done === 1'b0);
    end
    chk("reset_outputs", 64'(ok), 64'(1));
    chk("reset_no_pop", 64'(rd_cnt), 64'(0));
    rst = 1'b1;

    // Single byte 0x2A
    capture_frame("b2a_fall", txv, donev, ball, gap);
    chk("b2a_latency", 64'(gap), 64'(2));
    chk("b2a_frame", 64'(txv), 64'(exp_frame(8'h2A)));
    chk("b2a_done_pos", 64'(donev), 64'(done_last));
    chk("b2a_busy_frame", 64'(ball), 64'(1));
    @(negedge clk);
    chk("b2a_busy_after", 64'(busy), 64'(0));
    chk("b2a_pops", 64'(rd_cnt), 64'(1));
    chk("b2a_dones", 64'(done_cnt), 64'(1));

    // Back-to-back 0x1E, 0x37
    repeat (5) @(negedge clk);
    rd0 = rd_cnt;
    d0  = done_cnt;
    push(8'h1E);
    push(8'h37);
    capture_frame("b2b_fall1", txv, donev, ball, gap);
    capture_frame("b2b_fall2", txv2, donev2, ball2, gap2);
    @(negedge clk);
    chk("b2b_frame1", 64'(txv), 64'(exp_frame(8'h1E)));
    chk("b2b_frame2", 64'(txv2), 64'(exp_frame(8'h37)));
    chk("b2b_done1_pos", 64'(donev), 64'(done_last));
    chk("b2b_done2_pos", 64'(donev2), 64'(done_last));
    chk("b2b_gap", 64'(gap2), 64'(3));
    chk("b2b_pops", 64'(rd_cnt - rd0), 64'(2));
    chk("b2b_dones", 64'(done_cnt - d0), 64'(2));

    // Empty FIFO for 200 cycles
    rd0 = rd_cnt;
    ok  = 1'b1;
    repeat (200) begin
      @(negedge clk);
      ok = ok & (tx === 1'b1) & (busy === 1'b0) & (fifo_rd === 1'b0);
    end
    chk("empty_idle", 64'(ok), 64'(1));
    chk("empty_no_pop", 64'(rd_cnt - rd0), 64'(0));

    // Reset during data bit 3 of 0x57
    rd0 = rd_cnt;
    d0  = done_cnt;
    push(8'h57);
    wait_fall("r57_fall", gap, ok);
    repeat (4 * CPB + 1) @(negedge clk);
    chk("r57_bit3", 64'(tx), 64'(0));
    rst = 1'b0;
    #1;
    chk("r57_tx_imm", 64'(tx), 64'(1));
    chk("r57_busy_imm", 64'(busy), 64'(0));
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      ok = ok & (tx === 1'b1) & (busy === 1'b0) & (tx_done === 1'b0) & (fifo_rd === 1'b0);
    end
    chk("r57_in_reset", 64'(ok), 64'(1));
    rst = 1'b1;
    ok  = 1'b1;
    repeat (20) begin
      @(negedge clk);
      ok = ok & (tx === 1'b1) & (busy === 1'b0);
    end
    chk("r57_idle_after", 64'(ok), 64'(1));
    chk("r57_no_reread", 64'(rd_cnt - rd0), 64'(1));
    chk("r57_no_done", 64'(done_cnt - d0), 64'(0));
    push(8'hA5);
    capture_frame("ra5_fall", txv, donev, ball, gap);
    chk("ra5_latency", 64'(gap), 64'(2));
    chk("ra5_frame", 64'(txv), 64'(exp_frame(8'hA5)));
    chk("ra5_done_pos", 64'(donev), 64'(done_last));

    // Empty flag toggling every cycle while 0x55 is sent, 0xC3 queued behind
    repeat (3) @(negedge clk);
    rd0    = rd_cnt;
    tog_en = 1'b1;
    push(8'h55);
    push(8'hC3);
    capture_frame("tog_fall1", txv, donev, ball, gap);
    chk("tog_one_pop", 64'(rd_cnt - rd0), 64'(1));
    capture_frame("tog_fall2", txv2, donev2, ball2, gap2);
    chk("tog_frame1", 64'(txv), 64'(exp_frame(8'h55)));
    chk("tog_done1_pos", 64'(donev), 64'(done_last));
    chk("tog_busy_frame", 64'(ball), 64'(1));
    chk("tog_gap_3or4", 64'((gap2 == 3) || (gap2 == 4)), 64'(1));
    chk("tog_frame2", 64'(txv2), 64'(exp_frame(8'hC3)));
    tog_en = 1'b0;
    @(negedge clk);
    chk("tog_pops", 64'(rd_cnt - rd0), 64'(2));
    chk("no_underflow", 64'(underflow), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
